// File: rtl/random_delay_timer.sv
// rtl/random_delay_timer.sv - randomized wait-before-GO delay for the reaction-time game
// A free-running LFSR picks each delay; a ms prescaler times it.
module random_delay_timer #(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        delayCounterEnable,
  output logic        delayCounterDone,
  output logic [12:0] delayTarget,
  output logic [12:0] delayElapsed,
  output logic [1:0]  delayState
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } stateT;

  stateT         state, stateNext;
  logic [15:0]   lfsr;
  logic [PW-1:0] prescaler, prescalerNext;
  logic [12:0]   elapsedNext, targetNext;
  logic [12:0]   randDraw;
  logic          tickWrap;

  assign randDraw   = 13'(lfsr[RAND_BITS-1:0]);
  assign tickWrap   = (prescaler == TICK_LAST);
  assign delayState = state;

  always_comb begin
    stateNext     = state;
    prescalerNext = prescaler;
    elapsedNext   = delayElapsed;
    targetNext    = delayTarget;
    case (state)
      IDLE: begin
        if (delayCounterEnable) begin
          stateNext     = RUN;
          prescalerNext = '0;
          elapsedNext   = '0;
          targetNext    = 13'(MIN_DELAY_MS) + randDraw;
        end
      end
      RUN: begin
        // Counting continues on an abort edge, so a final wrap still lands in delayElapsed.
        prescalerNext = tickWrap ? '0 : prescaler + PW'(1);
        if (tickWrap) begin
          elapsedNext = delayElapsed + 13'd1;
        end
        if (!delayCounterEnable) begin
          stateNext = IDLE;
        end else if (tickWrap && (elapsedNext == delayTarget)) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state            <= IDLE;
      lfsr             <= 16'hACE1;
      prescaler        <= '0;
      delayElapsed     <= '0;
      delayTarget      <= '0;
      delayCounterDone <= 1'b0;
    end else begin
      state            <= stateNext;
      lfsr             <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      prescaler        <= prescalerNext;
      delayElapsed     <= elapsedNext;
      delayTarget      <= targetNext;
      delayCounterDone <= (stateNext == DONE);
    end
  end

endmodule

// File: tb/tb_random_delay_timer.sv
// tb/tb_random_delay_timer.sv - self-checking bench for random_delay_timer
// A behavioural model tracks expected outputs; a scoreboard checks each done pulse.
module tb_random_delay_timer;

  localparam int TICK  = 4;
  localparam int MINMS = 3;
  localparam int RB    = 2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        delayCounterEnable = 1'b0;
  logic        delayCounterDone;
  logic [12:0] delayTarget;
  logic [12:0] delayElapsed;
  logic [1:0]  delayState;

  random_delay_timer #(
    .TICK_DIV    (TICK),
    .MIN_DELAY_MS(MINMS),
    .RAND_BITS   (RB)
  ) dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .delayCounterEnable(delayCounterEnable),
    .delayCounterDone  (delayCounterDone),
    .delayTarget       (delayTarget),
    .delayElapsed      (delayElapsed),
    .delayState        (delayState)
  );

  always #5 Clock = ~Clock;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [15:0] mLfsr    = 16'hACE1;
  logic [1:0]  mState   = 2'd0;
  logic [12:0] mTarget  = 13'd0;
  logic [12:0] mElapsed = 13'd0;
  logic        mDone    = 1'b0;
  bit          mArmed   = 1'b0;
  int          mRun     = 0;
  logic        prevDone = 1'b0;
  int          sbq[$];

  function automatic logic [15:0] nextLfsr(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    nCompared++;
    assert (obs === expv) else begin
      nMismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input logic rst, input logic en);
    logic [15:0] pre;
    int          expT;
    Reset = rst;
    delayCounterEnable = en;
    pre = mLfsr;
    if (rst) begin
      mLfsr = 16'hACE1; mState = 2'd0; mTarget = '0; mElapsed = '0;
      mDone = 1'b0; mArmed = 1'b0; sbq.delete();
    end else begin
      mLfsr = nextLfsr(pre);
      case (mState)
        2'd0: if (en) begin
          mState = 2'd1; mRun = 0; mElapsed = '0; mArmed = 1'b1;
          mTarget = 13'(MINMS + int'(pre[RB-1:0]));
          sbq.delete();
          sbq.push_back(int'(mTarget));
        end
        2'd1: begin
          mRun++;
          mElapsed = 13'(mRun / TICK);
          if (!en) begin
            mState = 2'd0;
            sbq.delete();
          end else if (mElapsed == mTarget) begin
            mState = 2'd2;
          end
        end
        default: mState = 2'd0;
      endcase
      mDone = (mState == 2'd2);
    end
    @(posedge Clock);
    #1;
    chk("state", 16'(delayState), 16'(mState));
    chk("target", 16'(delayTarget), 16'(mTarget));
    chk("elapsed", 16'(delayElapsed), 16'(mElapsed));
    chk("done", 16'(delayCounterDone), 16'(mDone));
    chk("state_legal", 16'(delayState == 2'b11), 16'd0);
    chk("elapsed_le_target", 16'(delayElapsed <= delayTarget), 16'd1);
    chk("done_width", 16'(delayCounterDone && prevDone), 16'd0);
    chk("target_range", 16'(((delayTarget >= 13'd3) && (delayTarget <= 13'd6)) ||
                            (!mArmed && (delayTarget == 13'd0))), 16'd1);
    if (delayCounterDone === 1'b1) begin
      chk("sb_pending", 16'(sbq.size() != 0), 16'd1);
      if (sbq.size() != 0) begin
        expT = sbq.pop_front();
        chk("sb_target", 16'(delayTarget), 16'(expT));
        chk("sb_elapsed", 16'(delayElapsed), 16'(expT));
      end
    end
    prevDone = delayCounterDone;
  endtask

  initial begin
    int n;
    int pulses;
    int firstDone;
    int secondDone;
    int t2;

    // Basic delay
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("reset_done", 16'(delayCounterDone), 16'd0);
    chk("reset_target", 16'(delayTarget), 16'd0);
    chk("reset_elapsed", 16'(delayElapsed), 16'd0);
    chk("reset_state", 16'(delayState), 16'd0);
    tick(1'b0, 1'b1);
    chk("basic_target", 16'(delayTarget), 16'd4);
    chk("basic_state", 16'(delayState), 16'd1);
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0, 1'b1);
      if (k % 4 == 0) chk("basic_elapsed", 16'(delayElapsed), 16'(k / 4));
    end
    chk("basic_done", 16'(delayCounterDone), 16'd1);
    chk("basic_done_state", 16'(delayState), 16'd2);
    tick(1'b0, 1'b1);
    chk("basic_done_low", 16'(delayCounterDone), 16'd0);
    chk("basic_idle", 16'(delayState), 16'd0);

    // Later draw
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("later_target", 16'(delayTarget), 16'd6);
    n = 0;
    for (int k = 1; k <= 60 && delayCounterDone !== 1'b1; k++) begin
      tick(1'b0, 1'b1);
      n = k;
    end
    chk("later_latency", 16'(n), 16'd24);
    tick(1'b0, 1'b0);

    // Abort
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    for (int k = 0; k < 9; k++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("abort_state", 16'(delayState), 16'd0);
    chk("abort_elapsed", 16'(delayElapsed), 16'd2);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, 1'b0);
      if (delayCounterDone === 1'b1) pulses++;
    end
    chk("abort_no_done", 16'(pulses), 16'd0);
    chk("abort_elapsed_held", 16'(delayElapsed), 16'd2);

    // Back-to-back
    tick(1'b1, 1'b0);
    pulses = 0; firstDone = 0; secondDone = 0; t2 = 0;
    for (int k = 1; k <= 100 && pulses < 2; k++) begin
      tick(1'b0, 1'b1);
      if (delayCounterDone === 1'b1) begin
        pulses++;
        if (pulses == 1) firstDone = k;
        else begin
          secondDone = k;
          t2 = int'(mTarget);
        end
      end
    end
    chk("b2b_pulses", 16'(pulses), 16'd2);
    chk("b2b_first", 16'(firstDone), 16'd17);
    chk("b2b_gap", 16'(secondDone - firstDone), 16'(2 + TICK * t2));
    chk("b2b_range", 16'((t2 >= 3) && (t2 <= 6)), 16'd1);
    tick(1'b0, 1'b0);

    // Mid-run reset
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk("mrst_done", 16'(delayCounterDone), 16'd0);
    chk("mrst_target", 16'(delayTarget), 16'd0);
    chk("mrst_elapsed", 16'(delayElapsed), 16'd0);
    chk("mrst_state", 16'(delayState), 16'd0);
    tick(1'b0, 1'b1);
    chk("mrst_rearm_target", 16'(delayTarget), 16'd4);
    tick(1'b1, 1'b0);

    // Random arm/abort sequences
    for (int i = 0; i < 200; i++) begin
      n = int'($urandom_range(1, 40));
      for (int k = 0; k < n; k++) tick(1'b0, 1'b1);
      n = int'($urandom_range(0, 3));
      for (int k = 0; k < n; k++) tick(1'b0, 1'b0);
    end
    tick(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
